// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the IF/MM SRAM arbiter: FSM states, grantee encodings,
// and the wait-counter width helper.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_STATE_IDLE   = 2'd0,
        ARB_STATE_ACCESS = 2'd1,
        ARB_STATE_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_GNT_IF = 1'b0,
        ARB_GNT_MM = 1'b1
    } arb_gnt_e;

    // Counter must hold WAIT_CYCLES; keep at least one bit for single-cycle SRAM.
    function automatic int cnt_width(input int wait_cycles);
        return ($clog2(wait_cycles + 1) < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between IF and MM requests.
// SRAM_ARB_RR_EN: alternate winners on conflict; otherwise MM has fixed priority.
module sram_arb_pick
    import sram_bus_arbiter_pkg::*;
(
    input  logic     if_req,
    input  logic     mm_req,
    input  arb_gnt_e last_gnt,
    output logic     grant_valid,
    output arb_gnt_e grant
);

`ifdef SRAM_ARB_RR_EN
    always_comb begin
        grant_valid = if_req | mm_req;
        grant       = ARB_GNT_IF;
        if (if_req && mm_req)
            grant = (last_gnt == ARB_GNT_MM) ? ARB_GNT_IF : ARB_GNT_MM;
        else if (mm_req)
            grant = ARB_GNT_MM;
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        grant_valid = if_req | mm_req;
        grant       = mm_req ? ARB_GNT_MM : ARB_GNT_IF;
    end
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Single-port SRAM arbiter for IF and MM: one access at a time, WAIT_CYCLES extra
// cycles per access, one-cycle ready pulse. Optional SRAM_ARB_RR_EN round-robin.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mm_read,
    input  logic              mm_write,
    input  logic [31:0]       mm_addr,
    input  logic [31:0]       mm_wdata,
    input  logic [3:0]        mm_byte_en,
    output logic [31:0]       mm_rdata,
    output logic              mm_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_rdata,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    arb_gnt_e         gnt;
    arb_gnt_e         last_gnt;
    logic             op_write;

    logic             mm_req;
    logic             pick_valid;
    arb_gnt_e         pick_gnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mm_addr[31:ADDR_W+2], mm_addr[1:0]};

    assign mm_req = mm_read | mm_write;

    sram_arb_pick u_pick (
        .if_req      (if_req),
        .mm_req      (mm_req),
        .last_gnt    (last_gnt),
        .grant_valid (pick_valid),
        .grant       (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_STATE_IDLE;
            cnt          <= '0;
            gnt          <= ARB_GNT_IF;
            last_gnt     <= ARB_GNT_IF;
            op_write     <= 1'b0;
            if_ready     <= 1'b0;
            mm_ready     <= 1'b0;
            if_rdata     <= '0;
            mm_rdata     <= '0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_data_oe <= 1'b0;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
        end else begin
            if_ready <= 1'b0;
            mm_ready <= 1'b0;
            case (state)
                ARB_STATE_IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick_gnt;
                        last_gnt <= pick_gnt;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        state    <= ARB_STATE_ACCESS;
                        // Pins are loaded here so ACCESS sees only latched values.
                        if (pick_gnt == ARB_GNT_MM) begin
                            op_write     <= mm_write;
                            sram_addr    <= mm_addr[ADDR_W+1:2];
                            sram_wdata   <= mm_wdata;
                            sram_be_n    <= ~mm_byte_en;
                            sram_we_n    <= ~mm_write;
                            sram_oe_n    <= mm_write;
                            sram_data_oe <= mm_write;
                        end else begin
                            op_write     <= 1'b0;
                            sram_addr    <= if_addr[ADDR_W+1:2];
                            sram_be_n    <= 4'h0;
                            sram_we_n    <= 1'b1;
                            sram_oe_n    <= 1'b0;
                            sram_data_oe <= 1'b0;
                        end
                    end
                end
                ARB_STATE_ACCESS: begin
                    if (cnt == '0) begin
                        if (gnt == ARB_GNT_MM) begin
                            mm_ready <= 1'b1;
                            if (!op_write) mm_rdata <= sram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                        sram_oe_n    <= 1'b1;
                        sram_we_n    <= 1'b1;
                        sram_be_n    <= 4'hF;
                        sram_data_oe <= 1'b0;
                        state        <= ARB_STATE_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARB_STATE_DONE: state <= ARB_STATE_IDLE;
                default:        state <= ARB_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: WAIT_CYCLES=1 main instance plus a
// WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_sram_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // main DUT (WAIT_CYCLES = 1)
    logic        if_req = 0, mm_read = 0, mm_write = 0;
    logic [31:0] if_addr = 0, mm_addr = 0, mm_wdata = 0;
    logic [3:0]  mm_byte_en = 0;
    logic [31:0] if_rdata, mm_rdata, sram_wdata, sram_rdata;
    logic        if_ready, mm_ready, sram_data_oe, sram_oe_n, sram_we_n;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;

    // SRAM model: one special word, everything else tagged with its address
    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return (a == 20'h4) ? 32'hDEADBEEF : {12'hA5A, a};
    endfunction

    assign sram_rdata = mem_word(sram_addr);

    sram_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mm_read(mm_read), .mm_write(mm_write), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_byte_en(mm_byte_en), .mm_rdata(mm_rdata), .mm_ready(mm_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
        .sram_rdata(sram_rdata), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    // second DUT (WAIT_CYCLES = 0), IF only
    logic        z_if_req = 0;
    logic [31:0] z_if_addr = 0;
    logic        z_zero1 = 0;
    logic [31:0] z_zero32 = 0;
    logic [3:0]  z_zero4 = 0;
    logic [31:0] z_if_rdata, z_mm_rdata, z_sram_wdata, z_sram_rdata;
    logic        z_if_ready, z_mm_ready, z_sram_data_oe, z_sram_oe_n, z_sram_we_n;
    logic [19:0] z_sram_addr;
    logic [3:0]  z_sram_be_n;

    assign z_sram_rdata = mem_word(z_sram_addr);

    sram_bus_arbiter #(.WAIT_CYCLES(0), .ADDR_W(20)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata), .if_ready(z_if_ready),
        .mm_read(z_zero1), .mm_write(z_zero1), .mm_addr(z_zero32), .mm_wdata(z_zero32),
        .mm_byte_en(z_zero4), .mm_rdata(z_mm_rdata), .mm_ready(z_mm_ready),
        .sram_addr(z_sram_addr), .sram_wdata(z_sram_wdata), .sram_data_oe(z_sram_data_oe),
        .sram_rdata(z_sram_rdata), .sram_oe_n(z_sram_oe_n), .sram_we_n(z_sram_we_n),
        .sram_be_n(z_sram_be_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_mm;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // monitor: every ready pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (if_ready || mm_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready actual=if%0b_mm%0b required=none (cycle %0d)",
                         if_ready, mm_ready, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_port", {30'b0, if_ready, mm_ready}, {30'b0, ~e.is_mm, e.is_mm});
                chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                chk(e.is_mm ? "mm_rdata" : "if_rdata", e.is_mm ? mm_rdata : if_rdata, e.data);
            end
        end
    end

    task automatic wait_ready(input bit mm, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mm ? mm_ready : if_ready) && n < 40);
        if (!(mm ? mm_ready : if_ready)) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=no_ready required=ready", name);
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mm_last = 32'h0;
    int t0;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {30'b0, if_ready, mm_ready}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mm_rdata", mm_rdata, 32'h0);
        chk("rst_ctrl", {25'b0, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe},
            {25'b0, 1'b1, 1'b1, 4'hF, 1'b0});
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // IF read of 0x10 -> word 0x4
        if_req = 1; if_addr = 32'h0000_0010; t0 = cyc;
        sb.push_back('{0, 32'hDEADBEEF, t0 + 3});
        @(negedge clk);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("if_rd_addr", 32'(sram_addr), 32'h4);
            chk("if_rd_ctrl", {29'b0, sram_oe_n, sram_we_n, sram_data_oe}, {29'b0, 3'b010});
        end
        wait_ready(0, "if_rd");
        if_req = 0;

        // MM byte write, lane 2
        mm_write = 1; mm_addr = 32'h0000_0102; mm_byte_en = 4'b0100; mm_wdata = 32'h5A5A5A5A;
        t0 = cyc;
        sb.push_back('{1, mm_last, t0 + 3});
        @(negedge clk);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("mm_wr_addr", 32'(sram_addr), 32'h40);
            chk("mm_wr_ctrl", {25'b0, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe},
                {25'b0, 1'b1, 1'b0, 4'b1011, 1'b1});
            chk("mm_wr_wdata", sram_wdata, 32'h5A5A5A5A);
        end
        wait_ready(1, "mm_wr");
        mm_write = 0;

        // IF and MM read in the same cycle
        if_req = 1; if_addr = 32'h0000_0020; mm_read = 1; mm_addr = 32'h0000_0200;
        t0 = cyc;
`ifdef SRAM_ARB_RR_EN
        sb.push_back('{0, 32'hA5A00008, t0 + 3});
        sb.push_back('{1, 32'hA5A00080, t0 + 7});
        wait_ready(0, "conf_first");
        if_req = 0;
        wait_ready(1, "conf_second");
        mm_read = 0;
`else
        sb.push_back('{1, 32'hA5A00080, t0 + 3});
        sb.push_back('{0, 32'hA5A00008, t0 + 7});
        wait_ready(1, "conf_first");
        mm_read = 0;
        wait_ready(0, "conf_second");
        if_req = 0;
`endif
        mm_last = 32'hA5A00080;

        // read and write together behave as a write
        mm_read = 1; mm_write = 1; mm_addr = 32'h0000_0300; mm_byte_en = 4'hF;
        mm_wdata = 32'h12345678; t0 = cyc;
        sb.push_back('{1, mm_last, t0 + 3});
        @(negedge clk); @(negedge clk);
        chk("rw_ctrl", {29'b0, sram_oe_n, sram_we_n, sram_data_oe}, {29'b0, 3'b101});
        chk("rw_addr", 32'(sram_addr), 32'hC0);
        wait_ready(1, "rw");
        mm_read = 0; mm_write = 0;

        // write with no byte enables still runs and completes
        mm_write = 1; mm_addr = 32'h0000_0008; mm_byte_en = 4'h0; mm_wdata = 32'hCAFEF00D;
        t0 = cyc;
        sb.push_back('{1, mm_last, t0 + 3});
        @(negedge clk); @(negedge clk);
        chk("be0_ctrl", {26'b0, sram_we_n, sram_be_n, sram_data_oe}, {26'b0, 1'b0, 4'hF, 1'b1});
        wait_ready(1, "be0");
        mm_write = 0;

        // reset during the ACCESS of a write
        mm_write = 1; mm_addr = 32'h0000_0040; mm_byte_en = 4'hF; mm_wdata = 32'h0BADF00D;
        @(negedge clk); @(negedge clk);
        chk("abort_pre_we", {31'b0, sram_we_n}, 32'h0);
        rst = 1;
        @(negedge clk);
        chk("abort_pins", {26'b0, sram_we_n, sram_be_n, sram_data_oe}, {26'b0, 1'b1, 4'hF, 1'b0});
        chk("abort_ready", {31'b0, mm_ready}, 32'h0);
        rst = 0; mm_write = 0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;

        // fresh request after reset
        if_req = 1; if_addr = 32'h0000_0010; t0 = cyc;
        sb.push_back('{0, 32'hDEADBEEF, t0 + 3});
        wait_ready(0, "post_rst");
        if_req = 0;

        // WAIT_CYCLES=0: continuous IF fetch, one completion every 3 cycles
        z_if_req = 1; z_if_addr = 32'h0000_0100; t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!z_if_ready && n < 20);
            chk("z_ready_seen", {31'b0, z_if_ready}, 32'h1);
            chk("z_ready_cycle", 32'(cyc), 32'(t0 + ((i == 0) ? 2 : 3)));
            chk("z_rdata", z_if_rdata, {12'hA5A, 20'h40 + 20'(i)});
            t0 = cyc;
            @(posedge clk); #1;
            z_if_addr = z_if_addr + 32'd4;
        end
        z_if_req = 0;

        repeat (6) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares the single-port 32-bit SRAM between instruction fetch (IF) and the memory stage (MM). Accepts one word-wide request at a time and drives the SRAM for a configurable number of wait states. Returns read data and a one-cycle ready pulse to the granted requester. Sits between the IF/MM stages and the external SRAM pins; MM already supplies byte enables and lane-replicated write data.

Parameters:
WAIT_CYCLES, 1, extra SRAM access cycles beyond the first (0 = single-cycle SRAM)
ADDR_W, 20, SRAM word-address width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  IF read request, held until if_ready
if_addr  in  32  IF byte address (word-aligned)
if_rdata  out  32  IF read data, valid when if_ready
if_ready  out  1  one-cycle IF completion pulse
mm_read  in  1  MM read request, held until mm_ready
mm_write  in  1  MM write request, held until mm_ready
mm_addr  in  32  MM byte address
mm_wdata  in  32  MM write data, already lane-replicated
mm_byte_en  in  4  MM byte enables, bit i = byte lane i
mm_rdata  out  32  MM read data, raw word, valid when mm_ready
mm_ready  out  1  one-cycle MM completion pulse
sram_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2]
sram_wdata  out  32  write data to SRAM
sram_data_oe  out  1  drive sram_wdata onto the bidirectional bus
sram_rdata  in  32  read data from SRAM
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte enables, active low

Behaviour:
- States: IDLE, ACCESS, DONE; wait counter width clog2(WAIT_CYCLES+1), minimum 1.
- IDLE: mm_read|mm_write has priority over if_req. On a grant, latch address, wdata, byte_en (IF reads use 4'b1111), the op (write if mm_write), and grantee; load counter = WAIT_CYCLES; go to ACCESS. With no request, stay in IDLE.
- ACCESS: SRAM pins driven only from latched registers. Read: oe_n=0, we_n=1, data_oe=0. Write: we_n=0, oe_n=1, data_oe=1. be_n=~latched byte_en. Counter decrements each cycle. When counter==0: capture sram_rdata into grantee's rdata register; go to DONE.
- DONE: grantee's ready=1 for exactly this cycle. SRAM pins idle. Requests ignored. Next state IDLE.
- Latency: if request first seen in IDLE at cycle T, ready is high at T+WAIT_CYCLES+2. Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- Requester drops its request in the cycle after ready, or changes it to a new request; the arbiter never samples during DONE.
- Request inputs change mid-ACCESS: ignored; latched values are used.
- mm_read and mm_write both high: treated as write.
- Write with mm_byte_en=0: cycle still executed, be_n=4'hF, ready still pulses.
- mm_rdata on write completion: unchanged. if_rdata/mm_rdata hold their last value until overwritten.
- Reset values: state=IDLE, counter=0, if_ready=mm_ready=0, if_rdata=mm_rdata=0, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_data_oe=0, sram_addr=0, sram_wdata=0.
- Reset during ACCESS/DONE: transaction aborted, no ready pulse, pins idle on the next edge.
- All SRAM outputs registered; no combinational path from requester inputs to SRAM pins.

Optional Feature:
SRAM_ARB_RR_EN: when defined, a 1-bit last-grantee register (reset = IF) selects the winner when IF and MM request in the same IDLE cycle: the requester not granted last wins. A lone requester is always granted. Without the macro, MM wins all conflicts (fixed priority).

Decomposition:
- Shared defs include: state encodings ARB_STATE_IDLE/ACCESS/DONE (2-bit), grantee encodings ARB_GNT_IF/ARB_GNT_MM.
- One sub-module, sram_arb_pick: combinational winner select from if_req, mm_req and last-grantee, containing the SRAM_ARB_RR_EN logic.

Test Plan:
- WAIT_CYCLES=1, if_req at T0, addr 0x0000_0010, sram_rdata=0xDEADBEEF -> sram_addr=0x4 with oe_n=0 in T1–T2; if_ready=1 and if_rdata=0xDEADBEEF at T3.
- mm_write at T0, addr 0x0000_0102, byte_en=4'b0100, wdata=0x5A5A5A5A -> we_n=0, be_n=4'b1011, data_oe=1, sram_addr=0x40 for 2 cycles; mm_ready at T3; mm_rdata unchanged.
- if_req and mm_read both high at T0 -> MM granted, mm_ready at T3; IF granted at T4, if_ready at T7. With SRAM_ARB_RR_EN after a prior MM grant -> IF served first.
- WAIT_CYCLES=0, continuous if_req, address changing after each ready -> ready every 3 cycles, each rdata matching its address.
- rst asserted during the ACCESS of a write -> next edge: we_n=1, be_n=4'hF, no mm_ready; a fresh request after reset completes normally.
- mm_read and mm_write both high -> write cycle performed (we_n=0, oe_n=1).
